// File: rtl/control_unit_fsm.sv
// Multicycle RV32I control unit: Moore sequencer with ALU and immediate decoders.
// Supports lw, sw, R-type ALU, I-type ALU, beq and jal. Each takes 3-5 cycles.
module control_unit_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic       f7,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] inmSrc,
  output logic       regWrite,
  output logic [3:0] state
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t cur, nxt;
  logic [1:0] alu_op;
  logic pc_update, branch, reg_wr, mem_wr, ir_wr;

  always_ff @(posedge clk) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  assign state = cur;

  // Unused codes 11-15 fall through to FETCH.
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECUTER;
          OP_I:         nxt = S_EXECUTEI;
          OP_JAL:       nxt = S_JAL;
          OP_BEQ:       nxt = S_BEQ;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      nxt = S_MEMREAD;
        else if (op == OP_SW) nxt = S_MEMWRITE;
        else                  nxt = S_FETCH;
      end
      S_MEMREAD:                        nxt = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL:    nxt = S_ALUWB;
      default:                          nxt = S_FETCH;
    endcase
  end

  always_comb begin
    adrSrc    = 1'b0;
    resSrc    = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    alu_op    = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_wr    = 1'b0;
    mem_wr    = 1'b0;
    ir_wr     = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_wr = 1'b1; aluSrcB = 2'b10; resSrc = 2'b10; pc_update = 1'b1;
      end
      S_DECODE:   begin aluSrcA = 2'b01; aluSrcB = 2'b01; end
      S_MEMADR:   begin aluSrcA = 2'b10; aluSrcB = 2'b01; end
      S_MEMREAD:  adrSrc = 1'b1;
      S_MEMWB:    begin resSrc = 2'b01; reg_wr = 1'b1; end
      S_MEMWRITE: begin adrSrc = 1'b1; mem_wr = 1'b1; end
      S_EXECUTER: begin aluSrcA = 2'b10; alu_op = 2'b10; end
      S_EXECUTEI: begin aluSrcA = 2'b10; aluSrcB = 2'b01; alu_op = 2'b10; end
      S_ALUWB:    reg_wr = 1'b1;
      S_JAL:      begin aluSrcA = 2'b01; aluSrcB = 2'b10; pc_update = 1'b1; end
      S_BEQ:      begin aluSrcA = 2'b10; alu_op = 2'b01; branch = 1'b1; end
      default:    ;
    endcase
  end

  // Reset suppresses every write enable, whatever state the register holds.
  assign pcWrite  = ~reset & (pc_update | (branch & zero));
  assign irWrite  = ~reset & ir_wr;
  assign regWrite = ~reset & reg_wr;
  assign memWrite = ~reset & mem_wr;

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (f3)
          3'b000:  ALUControl = (op[5] & f7) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   inmSrc = 2'b01;
      OP_BEQ:  inmSrc = 2'b10;
      OP_JAL:  inmSrc = 2'b11;
      default: inmSrc = 2'b00;
    endcase
  end
endmodule

// File: tb/tb_control_unit_fsm.sv
// Randomized bench for control_unit_fsm; expectations come from per-instruction
// cycle sequences and the ISA decode rules, not from the state machine structure.
module tb_control_unit_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7, zero;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite;
  logic [1:0] resSrc, aluSrcA, aluSrcB, inmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  control_unit_fsm dut (
    .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
    .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
    .resSrc(resSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .ALUControl(ALUControl),
    .inmSrc(inmSrc), .regWrite(regWrite), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] fn3, input logic fn7);
    case (fn3)
      3'b000:  return (o == OP_R && fn7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // zmode: 0 zero held low, 1 held high, 2 random every cycle
  task automatic run_instr(input logic [6:0] o, input logic [2:0] fn3, input logic fn7, input int zmode);
    int seq[$];
    logic [2:0] e_alu;
    logic [1:0] e_imm, e_res;
    bit writes_reg;
    int last;
    case (o)
      OP_LW:   seq = '{0, 1, 2, 3, 4};
      OP_SW:   seq = '{0, 1, 2, 5};
      OP_R:    seq = '{0, 1, 6, 7};
      OP_I:    seq = '{0, 1, 8, 7};
      OP_JAL:  seq = '{0, 1, 9, 7};
      OP_BEQ:  seq = '{0, 1, 10};
      default: seq = '{0, 1};
    endcase
    case (o)
      OP_SW:   e_imm = 2'b01;
      OP_BEQ:  e_imm = 2'b10;
      OP_JAL:  e_imm = 2'b11;
      default: e_imm = 2'b00;
    endcase
    writes_reg = (o == OP_LW || o == OP_R || o == OP_I || o == OP_JAL);
    last = seq.size() - 1;
    for (int i = 0; i <= last; i++) begin
      op = o; f3 = fn3; f7 = fn7;
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      @(negedge clk);
      chk("state", 32'(state), 32'(seq[i]));
      chk("irWrite", 32'(irWrite), 32'(i == 0));
      chk("pcWrite", 32'(pcWrite),
          32'(i == 0 || (o == OP_JAL && i == 2) || (o == OP_BEQ && i == 2 && zero)));
      chk("regWrite", 32'(regWrite), 32'(writes_reg && i == last));
      chk("memWrite", 32'(memWrite), 32'(o == OP_SW && i == 3));
      chk("adrSrc", 32'(adrSrc), 32'((o == OP_LW || o == OP_SW) && i == 3));
      e_res = (i == 0) ? 2'b10 : (o == OP_LW && i == 4) ? 2'b01 : 2'b00;
      chk("resSrc", 32'(resSrc), 32'(e_res));
      if (i == 2 && o == OP_BEQ)                 e_alu = 3'b001;
      else if (i == 2 && (o == OP_R || o == OP_I)) e_alu = alu_ref(o, fn3, fn7);
      else                                        e_alu = 3'b000;
      chk("ALUControl", 32'(ALUControl), 32'(e_alu));
      chk("inmSrc", 32'(inmSrc), 32'(e_imm));
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_reset_enables();
    chk("rst_pcWrite", 32'(pcWrite), 32'd0);
    chk("rst_irWrite", 32'(irWrite), 32'd0);
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_memWrite", 32'(memWrite), 32'd0);
  endtask

  initial begin
    logic [6:0] pool [8];
    logic [6:0] o;
    pool = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ, 7'b1111111, 7'b0};
    reset = 1'b1; op = 7'b0; f3 = 3'b0; f7 = 1'b0; zero = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_reset_enables();
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // directed sequences
    run_instr(OP_LW, 3'b010, 1'b0, 2);
    run_instr(OP_SW, 3'b010, 1'b0, 2);
    run_instr(OP_R, 3'b000, 1'b1, 2);
    run_instr(OP_I, 3'b000, 1'b1, 2);
    run_instr(OP_R, 3'b010, 1'b0, 2);
    run_instr(OP_BEQ, 3'b000, 1'b0, 1);
    run_instr(OP_BEQ, 3'b000, 1'b0, 0);
    run_instr(OP_JAL, 3'b000, 1'b0, 2);
    run_instr(7'b1111111, 3'b000, 1'b0, 2);

    // reset in the middle of an R-type writeback
    op = OP_R; f3 = 3'b000; f7 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_state", 32'(state), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_enables();
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk_reset_enables();
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(OP_I, 3'b110, 1'b0, 2);

    // random instruction stream
    for (int n = 0; n < 300; n++) begin
      o = pool[$urandom_range(0, 7)];
      if (o == 7'b0) o = 7'($urandom);
      run_instr(o, 3'($urandom), 1'($urandom), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
